// File: rtl/rng_pkg.sv
// Shared constants and FSM state type for the random-number request arbiter.
package rng_pkg;

  localparam int unsigned RNG_WIDTH  = 12;
  localparam int unsigned RNG_SETTLE = 13;

  typedef enum logic [2:0] {
    IDLE,
    GEN,
    WAIT,
    DELIVER,
    COOL
  } state_t;

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first set request searching upward from ptr+1 with wrap.
module rr_pick
  import rng_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] sel,
  output logic               any
);

  int unsigned idx;

  // Scan NUM_REQ positions starting just after the last winner; first hit wins.
  always_comb begin
    sel = '0;
    any = 1'b0;
    idx = 0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      idx = (32'(ptr) + i) % NUM_REQ;
      if (!any && req[idx]) begin
        sel[idx] = 1'b1;
        any      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rng_request_arbiter.sv
// Shares one LFSR generator among NUM_REQ requesters: pulses the generate
// strobe, captures the fresh word and hands it to one round-robin winner.
module rng_request_arbiter
  import rng_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned WIDTH   = RNG_WIDTH,
  parameter int unsigned SETTLE  = RNG_SETTLE
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               enable,
  input  logic [NUM_REQ-1:0] req,
  input  logic [WIDTH-1:0]   rand_in,
  output logic               gen_out,
  output logic [NUM_REQ-1:0] grant,
  output logic [WIDTH-1:0]   rand_out,
  output logic               rand_valid,
  output logic               busy
);

  localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CNT_W = $clog2(SETTLE + 1);

  state_t             state;
  state_t             state_d;
  logic [PTR_W-1:0]   ptr;
  logic [PTR_W-1:0]   sel_idx;
  logic [NUM_REQ-1:0] sel_q;
  logic [NUM_REQ-1:0] pick_sel;
  logic               pick_any;
  logic [CNT_W-1:0]   cnt;
  logic               deliver_ok;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_pick (
    .req (req),
    .ptr (ptr),
    .sel (pick_sel),
    .any (pick_any)
  );

  // Encode the latched one-hot winner back to an index for the pointer.
  always_comb begin
    sel_idx = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (sel_q[i]) sel_idx = PTR_W'(i);
    end
  end

  // Grant decision is taken in WAIT so the registered grant, valid strobe and
  // captured word all appear together while the FSM sits in DELIVER.
  always_comb begin
    deliver_ok = (state == WAIT) && (|(req & sel_q));
  end

  // Next-state logic for the transaction sequence.
  always_comb begin
    state_d = state;
    unique case (state)
      IDLE:    if (enable && pick_any) state_d = GEN;
      GEN:     state_d = WAIT;
      WAIT:    state_d = DELIVER;
      DELIVER: state_d = COOL;
      COOL:    if (cnt == '0) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_d;
  end

  // Pointer, cooldown counter and registered outputs (driven from next state).
  always_ff @(posedge clock) begin
    if (reset) begin
      ptr        <= PTR_W'(NUM_REQ - 1);
      cnt        <= '0;
      sel_q      <= '0;
      gen_out    <= 1'b0;
      grant      <= '0;
      rand_out   <= '0;
      rand_valid <= 1'b0;
      busy       <= 1'b0;
    end else begin
      gen_out    <= (state_d == GEN);
      busy       <= (state_d != IDLE);
      grant      <= deliver_ok ? sel_q : '0;
      rand_valid <= deliver_ok;
      if (deliver_ok) rand_out <= rand_in;
      if (state == IDLE && state_d == GEN) sel_q <= pick_sel;
      if (state == DELIVER) begin
        ptr <= sel_idx;
        cnt <= CNT_W'(SETTLE - 1);
      end else if (state == COOL && cnt != '0) begin
        cnt <= cnt - CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_rng_request_arbiter.sv
// Directed bench for rng_request_arbiter with hand-computed expectations.
module tb_rng_request_arbiter;

  logic        clock;
  logic        reset;
  logic        enable;
  logic [3:0]  req;
  logic [11:0] rand_in;
  logic        gen_out;
  logic [3:0]  grant;
  logic [11:0] rand_out;
  logic        rand_valid;
  logic        busy;

  int vectors;
  int errs;
  logic prev_gen;

  rng_request_arbiter #(
    .NUM_REQ (4),
    .WIDTH   (12),
    .SETTLE  (13)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .enable     (enable),
    .req        (req),
    .rand_in    (rand_in),
    .gen_out    (gen_out),
    .grant      (grant),
    .rand_out   (rand_out),
    .rand_valid (rand_valid),
    .busy       (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock and sample 1 time unit after the edge; runs the monitors.
  task automatic tick();
    @(posedge clock);
    #1;
    check("gen_not_consecutive", 32'(gen_out & prev_gen), 32'd0);
    check("grant_onehot0", 32'($onehot0(grant)), 32'd1);
    check("valid_matches_grant", 32'(rand_valid), 32'(|grant));
    prev_gen = gen_out;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 40) begin
      tick();
      n++;
    end
    check(tag, 32'(busy), 32'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  int          gcyc[$];
  logic [3:0]  gval[$];
  logic [11:0] gword[$];

  initial begin
    vectors  = 0;
    errs     = 0;
    prev_gen = 1'b0;
    reset    = 1'b1;
    enable   = 1'b1;
    req      = 4'b0000;
    rand_in  = 12'h000;

    // Reset state
    tick();
    tick();
    check("rst_gen", 32'(gen_out), 32'd0);
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_rand_out", 32'(rand_out), 32'd0);
    check("rst_valid", 32'(rand_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);

    // Single request, latency check
    reset   = 1'b0;
    req     = 4'b0001;
    rand_in = 12'hA5C;
    tick();
    check("t1_gen_c1", 32'(gen_out), 32'd1);
    check("t1_busy_c1", 32'(busy), 32'd1);
    tick();
    check("t1_gen_c2", 32'(gen_out), 32'd0);
    check("t1_grant_c2", 32'(grant), 32'd0);
    tick();
    check("t1_grant_c3", 32'(grant), 32'b0001);
    check("t1_valid_c3", 32'(rand_valid), 32'd1);
    check("t1_word_c3", 32'(rand_out), 32'hA5C);
    req     = 4'b0000;
    rand_in = 12'h111;
    tick();
    check("t1_grant_c4", 32'(grant), 32'd0);
    check("t1_word_hold", 32'(rand_out), 32'hA5C);
    repeat (12) tick();
    check("t1_busy_c16", 32'(busy), 32'd1);
    tick();
    check("t1_busy_c17", 32'(busy), 32'd0);

    // All four requesting: round robin 0,1,2,3,0 every 17 cycles
    do_reset();
    req     = 4'b1111;
    rand_in = 12'h100;
    for (int c = 1; c <= 80; c++) begin
      tick();
      if (grant != 4'b0000) begin
        gcyc.push_back(c);
        gval.push_back(grant);
        gword.push_back(rand_out);
        if (gcyc.size() == 5) req = 4'b0000;
      end
      rand_in = 12'h100 + 12'(c);
    end
    check("t2_grant_count", 32'(gcyc.size()), 32'd5);
    for (int k = 0; k < 5 && k < gcyc.size(); k++) begin
      check("t2_grant_cycle", 32'(gcyc[k]), 32'(3 + 17 * k));
      check("t2_grant_id", 32'(gval[k]), 32'(4'b0001 << (k % 4)));
      check("t2_grant_word", 32'(gword[k]), 32'(12'h100 + 12'(2 + 17 * k)));
    end
    wait_idle("t2_idle_timeout");

    // Request dropped before delivery: no grant, word unchanged
    req     = 4'b0100;
    rand_in = 12'h3C3;
    tick();
    check("t3_gen", 32'(gen_out), 32'd1);
    req = 4'b0000;
    tick();
    tick();
    check("t3_no_grant", 32'(grant), 32'd0);
    check("t3_no_valid", 32'(rand_valid), 32'd0);
    check("t3_word_kept", 32'(rand_out), 32'h146);
    check("t3_busy", 32'(busy), 32'd1);
    wait_idle("t3_idle_timeout");
    req     = 4'b0110;
    rand_in = 12'h777;
    repeat (3) tick();
    check("t3_rr_grant", 32'(grant), 32'b0010);
    check("t3_rr_word", 32'(rand_out), 32'h777);
    req = 4'b0000;
    wait_idle("t3b_idle_timeout");

    // Enable low blocks new starts
    enable  = 1'b0;
    req     = 4'b0010;
    rand_in = 12'h0F0;
    repeat (5) tick();
    check("t4_gen_blocked", 32'(gen_out), 32'd0);
    check("t4_busy_blocked", 32'(busy), 32'd0);
    enable = 1'b1;
    tick();
    check("t4_gen", 32'(gen_out), 32'd1);
    tick();
    tick();
    check("t4_grant", 32'(grant), 32'b0010);
    check("t4_word", 32'(rand_out), 32'h0F0);
    req = 4'b0000;
    wait_idle("t4_idle_timeout");

    // Reset while in WAIT drops the transaction
    req     = 4'b0001;
    rand_in = 12'hBEE;
    tick();
    tick();
    reset = 1'b1;
    tick();
    check("t5_rst_gen", 32'(gen_out), 32'd0);
    check("t5_rst_grant", 32'(grant), 32'd0);
    check("t5_rst_valid", 32'(rand_valid), 32'd0);
    check("t5_rst_word", 32'(rand_out), 32'd0);
    check("t5_rst_busy", 32'(busy), 32'd0);
    reset   = 1'b0;
    req     = 4'b1001;
    rand_in = 12'h5A5;
    tick();
    tick();
    check("t5_no_grant_c2", 32'(grant), 32'd0);
    tick();
    check("t5_grant0_first", 32'(grant), 32'b0001);
    check("t5_word", 32'(rand_out), 32'h5A5);
    req = 4'b1000;
    wait_idle("t5_idle_timeout");
    repeat (3) tick();
    check("t5_grant3_next", 32'(grant), 32'b1000);
    req = 4'b0000;
    wait_idle("t5b_idle_timeout");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
